tbl_seed_pipe: RTL and testbench

Parametrised, pipelined successor to the math unit's seed lookup table. It serves reciprocal/rsqrt-style seed lookups for up to N_FUNC function banks from one RAM. The index is derived from the operand's exponent window and top mantissa bits. It adds a valid/ready handshake, a 2-stage read pipeline with stall, write-first bypass, out-of-range flagging, and a self-clearing init/soft-clear state machine. It sits between the FP divide/sqrt front end and its Newton-iteration datapath.

---
 rtl/math_tbl_pkg.sv | 17 +
 rtl/tbl_seed_ram.sv | 27 ++
 rtl/tbl_seed_pipe.sv | 168 ++++++++++++++++
 tb/tb_tbl_seed_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/math_tbl_pkg.sv
// rtl/math_tbl_pkg.sv - shared types and defaults for the seed lookup table
package math_tbl_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_READY,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] OOR_NONE = 2'b00;
  localparam logic [1:0] OOR_LO   = 2'b01;
  localparam logic [1:0] OOR_HI   = 2'b10;

  localparam int unsigned DEF_WIN_LO   = 2041;
  localparam logic [3:0]  DEF_SIGN_FIX = 4'b0101;

endpackage

// File: rtl/tbl_seed_ram.sv
// rtl/tbl_seed_ram.sv - single-clock seed RAM, one write and one registered read port
// A read of the address being written in the same cycle returns the new data.
module tbl_seed_ram #(
  parameter int AW = 10,
  parameter int W  = 68
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tbl_seed_pipe.sv
// rtl/tbl_seed_pipe.sv - pipelined seed lookup with handshake, bypass and self-clearing init
// Index from the operand exponent window plus top mantissa bits; two-stage read with stall.
module tbl_seed_pipe
  import math_tbl_pkg::*;
#(
  parameter int W        = 68,
  parameter int N_FUNC   = 4,
  parameter int SEG_BITS = 3,
  parameter int SEGS     = 6,
  parameter int MAN_BITS = 5,
  parameter int WIN_LO   = DEF_WIN_LO,
  parameter logic [N_FUNC-1:0] SIGN_FIX = DEF_SIGN_FIX,
  parameter int TAG_W    = 4,
  localparam int FB      = $clog2(N_FUNC),
  localparam int AW      = FB + SEG_BITS + MAN_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [W-1:0]     in_a,
  input  logic [FB-1:0]    in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_oor,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic             clr_req,
  output logic             init_busy
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             s1_vld_q, s1_sgn_q;
  logic [AW-1:0]    s1_addr_q;
  logic [1:0]       s1_oor_q;
  logic [FB-1:0]    s1_func_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             out_vld_q;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q;
  logic [1:0]       out_oor_q;

  logic [11:0]      exp_w, diff_w;
  logic [1:0]       oor_w;
  logic [AW-1:0]    addr_w;
  logic             stall_w, accept_w, clearing_w;
  logic             ram_we_w;
  logic [AW-1:0]    ram_waddr_w, ram_raddr_w;
  logic [W-1:0]     ram_wdata_w, ram_rdata_w;
  logic             unused_w;

  assign exp_w  = in_a[65:54];
  assign diff_w = exp_w - 12'(WIN_LO);
  assign addr_w = {in_func, diff_w[SEG_BITS-1:0], in_a[53 -: MAN_BITS]};
  assign unused_w = ^{in_a[W-1:66], in_a[53-MAN_BITS:0]};

  // Checking d against SEGS only after E >= WIN_LO avoids overflow of WIN_LO+SEGS.
  always_comb begin
    oor_w = OOR_NONE;
    if (exp_w < 12'(WIN_LO)) begin
      oor_w = OOR_LO;
    end else if (diff_w >= 12'(SEGS)) begin
      oor_w = OOR_HI;
    end
  end

  assign stall_w    = out_vld_q && !out_rdy;
  assign in_rdy     = (state_q == ST_READY) && !stall_w;
  assign accept_w   = in_vld && in_rdy;
  assign clearing_w = (state_q == ST_CLEAR);
  assign init_busy  = (state_q != ST_READY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = ST_READY;
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = (s1_vld_q || out_vld_q) ? ST_DRAIN : ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !out_vld_q) state_d = ST_CLEAR;
        cnt_d = '0;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Under stall the read keeps re-targeting the held S1 address so late writes land.
  assign ram_we_w    = clearing_w || wr_en;
  assign ram_waddr_w = clearing_w ? cnt_q : wr_addr;
  assign ram_wdata_w = clearing_w ? '0 : wr_data;
  assign ram_raddr_w = stall_w ? s1_addr_q : addr_w;

  tbl_seed_ram #(
    .AW (AW),
    .W  (W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_w),
    .waddr_i (ram_waddr_w),
    .wdata_i (ram_wdata_w),
    .raddr_i (ram_raddr_w),
    .rdata_o (ram_rdata_w)
  );

  always_comb begin
    out_data_d     = ram_rdata_w;
    out_data_d[64] = ram_rdata_w[64] ^ (SIGN_FIX[s1_func_q] & s1_sgn_q);
    if (s1_oor_q != OOR_NONE) out_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_oor_q   <= OOR_NONE;
      s1_func_q  <= '0;
      s1_sgn_q   <= 1'b0;
      s1_tag_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      out_oor_q  <= OOR_NONE;
    end else if (!stall_w) begin
      s1_vld_q   <= accept_w;
      s1_addr_q  <= addr_w;
      s1_oor_q   <= oor_w;
      s1_func_q  <= in_func;
      s1_sgn_q   <= in_a[64];
      s1_tag_q   <= in_tag;
      out_vld_q  <= s1_vld_q;
      out_data_q <= out_data_d;
      out_tag_q  <= s1_tag_q;
      out_oor_q  <= s1_oor_q;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;
  assign out_oor  = out_oor_q;

endmodule

// File: tb/tb_tbl_seed_pipe.sv
// tb/tb_tbl_seed_pipe.sv - directed self-checking bench for tbl_seed_pipe
module tb_tbl_seed_pipe;

  localparam int W     = 68;
  localparam int TAG_W = 4;
  localparam int FB    = 2;
  localparam int AW    = 10;

  localparam logic [W-1:0] D1     = 68'h0_1234_5678_9ABC_DEF0;
  localparam logic [W-1:0] D1_FIX = 68'h1_1234_5678_9ABC_DEF0;
  localparam logic [W-1:0] D2     = 68'h2_0F0F_0F0F_0F0F_0F0F;
  localparam logic [W-1:0] D3     = 68'h5_AAAA_BBBB_CCCC_DDDD;
  localparam logic [W-1:0] BP_BASE = 68'hC_5555_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld, in_rdy;
  logic [W-1:0]     in_a;
  logic [FB-1:0]    in_func;
  logic [TAG_W-1:0] in_tag;
  logic             out_vld, out_rdy;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_oor;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic             clr_req, init_busy;

  int n_checks = 0;
  int n_errors = 0;

  tbl_seed_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_a      (in_a),
    .in_func   (in_func),
    .in_tag    (in_tag),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_oor   (out_oor),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_a(input logic [11:0] e, input logic [4:0] m);
    logic [W-1:0] a;
    a = '0;
    a[65:54] = e;
    a[53:49] = m;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
    wr_en = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [FB-1:0] f, input logic [11:0] e, input logic [4:0] m,
                        input logic [TAG_W-1:0] t, output int lat, output logic [W-1:0] d,
                        output logic [1:0] o, output logic [TAG_W-1:0] tg);
    in_vld = 1'b1;
    in_func = f;
    in_a = mk_a(e, m);
    in_tag = t;
    out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 20) begin
      tick();
      lat++;
    end
    d = out_data;
    o = out_oor;
    tg = out_tag;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (out_vld !== 1'b0) begin n_errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_tag !== '0) begin n_errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    n_checks++; if (out_oor !== 2'b00) begin n_errors++; $display("FAIL reset_out_oor got %b want 00", out_oor); end
    n_checks++; if (init_busy !== 1'b1) begin n_errors++; $display("FAIL reset_init_busy got %b want 1", init_busy); end
    n_checks++; if (in_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
  endtask

  task automatic test_init_clear();
    int n;
    int busy_bad;
    int lat;
    logic [W-1:0] d;
    logic [1:0] o;
    logic [TAG_W-1:0] tg;
    in_vld = 1'b1;
    in_func = 2'd1;
    in_a = mk_a(12'd2043, 5'h0A);
    rst = 1'b1;
    n = 0;
    busy_bad = 0;
    while (!in_rdy && n < 2000) begin
      tick();
      n++;
      if (!in_rdy && init_busy !== 1'b1) busy_bad++;
    end
    in_vld = 1'b0;
    n_checks++; if (n != 1024) begin n_errors++; $display("FAIL init_clear_cycles got %0d want 1024", n); end
    n_checks++; if (busy_bad != 0) begin n_errors++; $display("FAIL init_busy_during_clear got %0d bad cycles want 0", busy_bad); end
    n_checks++; if (init_busy !== 1'b0) begin n_errors++; $display("FAIL init_busy_after got %b want 0", init_busy); end
    lookup(2'd3, 12'd2045, 5'h07, 4'h2, lat, d, o, tg);
    n_checks++; if (d !== '0) begin n_errors++; $display("FAIL init_cleared_data got %h want 0", d); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [W-1:0] d;
    logic [1:0] o;
    logic [TAG_W-1:0] tg;
    do_write(10'h14A, D1);
    lookup(2'd1, 12'd2043, 5'h0A, 4'h9, lat, d, o, tg);
    n_checks++; if (lat != 2) begin n_errors++; $display("FAIL wr_rd_latency got %0d want 2", lat); end
    n_checks++; if (d !== D1) begin n_errors++; $display("FAIL wr_rd_data got %h want %h", d, D1); end
    n_checks++; if (o !== 2'b00) begin n_errors++; $display("FAIL wr_rd_oor got %b want 00", o); end
    n_checks++; if (tg !== 4'h9) begin n_errors++; $display("FAIL wr_rd_tag got %h want 9", tg); end
  endtask

  task automatic test_sign_fix();
    int lat;
    logic [W-1:0] d;
    logic [1:0] o;
    logic [TAG_W-1:0] tg;
    do_write(10'h04A, D1);
    lookup(2'd0, 12'd2043, 5'h0A, 4'h3, lat, d, o, tg);
    n_checks++; if (d !== D1_FIX) begin n_errors++; $display("FAIL sign_fix_func0 got %h want %h", d, D1_FIX); end
    lookup(2'd1, 12'd2043, 5'h0A, 4'h4, lat, d, o, tg);
    n_checks++; if (d !== D1) begin n_errors++; $display("FAIL sign_fix_func1 got %h want %h", d, D1); end
  endtask

  task automatic test_oor();
    int lat;
    logic [W-1:0] d;
    logic [1:0] o;
    logic [TAG_W-1:0] tg;
    lookup(2'd1, 12'd2040, 5'h0A, 4'h1, lat, d, o, tg);
    n_checks++; if (o !== 2'b01) begin n_errors++; $display("FAIL oor_lo_flag got %b want 01", o); end
    n_checks++; if (d !== '0) begin n_errors++; $display("FAIL oor_lo_data got %h want 0", d); end
    lookup(2'd1, 12'd2047, 5'h0A, 4'h1, lat, d, o, tg);
    n_checks++; if (o !== 2'b10) begin n_errors++; $display("FAIL oor_hi_flag got %b want 10", o); end
    n_checks++; if (d !== '0) begin n_errors++; $display("FAIL oor_hi_data got %h want 0", d); end
    do_write(10'h1A0, D2);
    lookup(2'd1, 12'd2046, 5'h00, 4'h1, lat, d, o, tg);
    n_checks++; if (o !== 2'b00) begin n_errors++; $display("FAIL top_seg_flag got %b want 00", o); end
    n_checks++; if (d !== D2) begin n_errors++; $display("FAIL top_seg_data got %h want %h", d, D2); end
  endtask

  task automatic test_back_to_back();
    int c;
    int nxt;
    int got;
    int stalls;
    logic [W-1:0] exp_d;
    for (int t = 0; t < 4; t++) do_write(10'h100 + 10'(t), BP_BASE + 68'(t));
    c = 0;
    nxt = 0;
    got = 0;
    stalls = 0;
    while (got < 4 && c < 40) begin
      out_rdy = !(c >= 3 && c <= 6);
      in_vld = (nxt < 4);
      in_func = 2'd1;
      in_a = mk_a(12'd2041, 5'(nxt));
      in_tag = 4'(nxt);
      #1;
      if (out_vld) begin
        exp_d = BP_BASE + 68'(out_tag);
        n_checks++;
        if (out_data !== exp_d || out_tag > 4'd3) begin
          n_errors++;
          $display("FAIL bp_data cycle %0d tag %0d got %h want %h", c, out_tag, out_data, exp_d);
        end
        if (!out_rdy) stalls++;
        else begin
          n_checks++;
          if (out_tag !== 4'(got)) begin n_errors++; $display("FAIL bp_order got %0d want %0d", out_tag, got); end
          got++;
        end
      end
      if (in_vld && in_rdy) nxt++;
      tick();
      c++;
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    n_checks++; if (got != 4) begin n_errors++; $display("FAIL bp_delivered got %0d want 4", got); end
    n_checks++; if (stalls != 4) begin n_errors++; $display("FAIL bp_stall_cycles got %0d want 4", stalls); end
    tick();
    n_checks++; if (out_vld !== 1'b0) begin n_errors++; $display("FAIL bp_no_extra got %b want 0", out_vld); end
  endtask

  task automatic test_soft_clear();
    int got;
    int k;
    int n;
    int lat;
    logic [W-1:0] d;
    logic [1:0] o;
    logic [TAG_W-1:0] tg;
    out_rdy = 1'b0;
    in_vld = 1'b1;
    in_func = 2'd1;
    in_a = mk_a(12'd2043, 5'h0A);
    in_tag = 4'h5;
    tick();
    in_tag = 4'h6;
    tick();
    in_vld = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n_checks++; if (init_busy !== 1'b1) begin n_errors++; $display("FAIL drain_busy got %b want 1", init_busy); end
    n_checks++; if (in_rdy !== 1'b0) begin n_errors++; $display("FAIL drain_in_rdy got %b want 0", in_rdy); end
    out_rdy = 1'b1;
    got = 0;
    k = 0;
    while (got < 2 && k < 10) begin
      if (out_vld) begin
        n_checks++;
        if (out_tag !== 4'(5 + got) || out_data !== D1) begin
          n_errors++;
          $display("FAIL drain_result tag %0d data %h want tag %0d data %h", out_tag, out_data, 5 + got, D1);
        end
        got++;
      end
      tick();
      k++;
    end
    n_checks++; if (got != 2) begin n_errors++; $display("FAIL drain_completed got %0d want 2", got); end
    n = 0;
    while (!in_rdy && n < 2000) begin
      tick();
      n++;
    end
    n_checks++; if (n != 1025) begin n_errors++; $display("FAIL soft_clear_cycles got %0d want 1025", n); end
    lookup(2'd1, 12'd2043, 5'h0A, 4'h7, lat, d, o, tg);
    n_checks++; if (d !== '0) begin n_errors++; $display("FAIL soft_cleared_data got %h want 0", d); end
    wr_en = 1'b1;
    wr_addr = 10'h14A;
    wr_data = D3;
    in_vld = 1'b1;
    in_func = 2'd1;
    in_a = mk_a(12'd2043, 5'h0A);
    in_tag = 4'hB;
    tick();
    wr_en = 1'b0;
    in_vld = 1'b0;
    tick();
    n_checks++; if (out_vld !== 1'b1) begin n_errors++; $display("FAIL bypass_vld got %b want 1", out_vld); end
    n_checks++; if (out_data !== D3) begin n_errors++; $display("FAIL bypass_data got %h want %h", out_data, D3); end
    n_checks++; if (out_tag !== 4'hB) begin n_errors++; $display("FAIL bypass_tag got %h want b", out_tag); end
  endtask

  initial begin
    rst = 1'b0;
    in_vld = 1'b0;
    in_a = '0;
    in_func = '0;
    in_tag = '0;
    out_rdy = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
    test_reset();
    test_init_clear();
    test_write_read();
    test_sign_fix();
    test_oor();
    test_back_to_back();
    test_soft_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
